// File: rtl/mnist_pkg.sv
// mnist_pkg
// Shared constants and types for the MNIST network datapath.
//  KERNEL_SIZE / NUM_CHANNELS : convolution geometry
//  CONV2_*                     : conv2 feature-map geometry and read-path timing
//  conv2_seq_state_t           : conv2 frame sequencer states
//  conv2_win_tag_t             : window qualification tag carried alongside the buffer latency
//  cnt_w()                     : counter width for a range 0..n-1 (never below 1 bit)
package mnist_pkg;

  localparam int KERNEL_SIZE   = 3;
  localparam int NUM_CHANNELS  = 8;

  localparam int CONV2_MAP_W   = 13;
  localparam int CONV2_MAP_H   = 13;
  localparam int CONV2_ADDR_W  = 8;
  localparam int CONV2_BUF_LAT = 1;

  // Window coordinates leave the block on fixed 4-bit ports.
  localparam int WIN_COORD_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } conv2_seq_state_t;

  typedef struct packed {
    logic                   vld;
    logic                   last;
    logic [WIN_COORD_W-1:0] row;
    logic [WIN_COORD_W-1:0] col;
  } conv2_win_tag_t;

  function automatic int cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv2_seq_ctrl_if.sv
// conv2_seq_ctrl_if
// Bundles the conv2 sequencer's handshake, RAM read port and window-buffer outputs.
//  Parameter ADDR_W : RAM address width
//  modport master   : network FSM / RAM / window-buffer side (drives start, fm_rd_data)
//  modport slave    : sequencer side (drives everything else)
interface conv2_seq_ctrl_if
  import mnist_pkg::*;
#(
  parameter int ADDR_W = CONV2_ADDR_W
) ();

  logic                    start;
  logic                    busy;
  logic                    done;
  logic                    fm_rd_en;
  logic [ADDR_W-1:0]       fm_rd_addr;
  logic [NUM_CHANNELS-1:0] fm_rd_data;
  logic [NUM_CHANNELS-1:0] buf_pixel;
  logic                    win_valid;
  logic [WIN_COORD_W-1:0]  win_row;
  logic [WIN_COORD_W-1:0]  win_col;
  logic                    win_last;

  modport master (
    output start,
    output fm_rd_data,
    input  busy,
    input  done,
    input  fm_rd_en,
    input  fm_rd_addr,
    input  buf_pixel,
    input  win_valid,
    input  win_row,
    input  win_col,
    input  win_last
  );

  modport slave (
    input  start,
    input  fm_rd_data,
    output busy,
    output done,
    output fm_rd_en,
    output fm_rd_addr,
    output buf_pixel,
    output win_valid,
    output win_row,
    output win_col,
    output win_last
  );

endinterface

// File: rtl/conv2_pos_cnt.sv
// conv2_pos_cnt
// Raster row/column counter over a WIDTH x HEIGHT map. The column wraps from WIDTH-1 to 0
// and bumps the row; the row wraps from HEIGHT-1 to 0, so the counter returns to (0,0) on
// its own after the last position.
//  clk, rst_n : clock, asynchronous active-low reset
//  i_clr      : synchronous clear to (0,0), wins over i_en
//  i_en       : advance one position
//  o_row/o_col: current position
//  o_col_end  : column is at WIDTH-1 (next advance wraps the column)
//  o_last     : position is (HEIGHT-1, WIDTH-1) (next advance wraps the frame)
module conv2_pos_cnt
  import mnist_pkg::*;
#(
  parameter  int WIDTH  = CONV2_MAP_W,
  parameter  int HEIGHT = CONV2_MAP_H,
  localparam int COL_W  = cnt_w(WIDTH),
  localparam int ROW_W  = cnt_w(HEIGHT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [ROW_W-1:0] o_row,
  output logic [COL_W-1:0] o_col,
  output logic             o_col_end,
  output logic             o_last
);

  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;
  logic             w_col_end;
  logic             w_row_end;

  assign w_col_end = (r_col == COL_W'(WIDTH - 1));
  assign w_row_end = (r_row == ROW_W'(HEIGHT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_clr) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_en) begin
      if (w_col_end) begin
        r_col <= '0;
        r_row <= w_row_end ? '0 : r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  assign o_row     = r_row;
  assign o_col     = r_col;
  assign o_col_end = w_col_end;
  assign o_last    = w_col_end & w_row_end;

endmodule

// File: rtl/conv2_seq_ctrl.sv
// conv2_seq_ctrl
// Frame sequencer for the conv2 stage. Streams one 8-channel feature map from the conv1
// output RAM into the conv2 3x3 window buffer at one pixel per cycle, tracks the window
// position, qualifies interior windows only, and reports frame completion with a
// start/busy/done handshake.
//  Parameters : WIDTH, HEIGHT (map size, >= 3), ADDR_W (RAM address width),
//               BUF_LAT (cycles from buf_pixel to the window it completes, >= 1)
//  clk, rst_n : clock, asynchronous active-low reset
//  bus        : conv2_seq_ctrl_if.slave -- start/busy/done, fm_rd_en/addr/data,
//               buf_pixel, win_valid/row/col/last
//  Optional (macro CONV2_SEQ_PERF_EN):
//   perf_frames   : completed-frame count, wraps
//   perf_busy_cyc : cycles with busy=1, saturates
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; read and pixel paths quiet
// READ  | one RAM read per cycle, raster order, WIDTH*HEIGHT cycles
// DRAIN | last pixel and its window flow through (1+BUF_LAT cycles)
// DONE  | one-cycle done pulse, back to IDLE
module conv2_seq_ctrl
  import mnist_pkg::*;
#(
  parameter int WIDTH   = CONV2_MAP_W,
  parameter int HEIGHT  = CONV2_MAP_H,
  parameter int ADDR_W  = CONV2_ADDR_W,
  parameter int BUF_LAT = CONV2_BUF_LAT
) (
  input  logic          clk,
  input  logic          rst_n,
  conv2_seq_ctrl_if.slave bus
`ifdef CONV2_SEQ_PERF_EN
  ,
  output logic [15:0]   perf_frames,
  output logic [31:0]   perf_busy_cyc
`endif
);

  localparam int COL_W = cnt_w(WIDTH);
  localparam int ROW_W = cnt_w(HEIGHT);
  localparam int LAT_W = $clog2(BUF_LAT + 1);
  localparam int KM1   = KERNEL_SIZE - 1;

  conv2_seq_state_t r_state;
  conv2_seq_state_t w_state_nxt;

  logic             w_start_acc;
  logic             w_busy;
  logic             w_done;
  logic             w_rd_en;
  logic             w_rd_last;
  logic [ROW_W-1:0] w_rd_row;
  logic [COL_W-1:0] w_rd_col;
  logic             w_rd_col_end;

  logic             r_rd_en_d1;
  logic             w_pix_vld;
  logic [ROW_W-1:0] w_px_row;
  logic [COL_W-1:0] w_px_col;
  logic             w_px_col_end;
  logic             w_px_last;
  logic             w_qual;

  logic [LAT_W-1:0] r_drain_cnt;

  conv2_win_tag_t   w_tag_in;
  conv2_win_tag_t   r_tag_pipe [BUF_LAT];
  conv2_win_tag_t   w_tag_out;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_rd_en     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_start_acc = 1'b1;
          w_state_nxt = READ;
        end
      end
      READ: begin
        w_busy  = 1'b1;
        w_rd_en = 1'b1;
        if (w_rd_last) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        w_busy = 1'b1;
        if (r_drain_cnt == '0) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Drain timer: loaded as the last address issues, terminal count 0 ends DRAIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drain_cnt <= '0;
    end else if (r_state == READ && w_rd_last) begin
      r_drain_cnt <= LAT_W'(BUF_LAT);
    end else if (r_state == DRAIN && r_drain_cnt != '0) begin
      r_drain_cnt <= r_drain_cnt - LAT_W'(1);
    end
  end

  // ---------------------------------------------------------------- read address
  conv2_pos_cnt #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_rd_pos (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_start_acc),
    .i_en      (w_rd_en),
    .o_row     (w_rd_row),
    .o_col     (w_rd_col),
    .o_col_end (w_rd_col_end),
    .o_last    (w_rd_last)
  );

  assign bus.fm_rd_en   = w_rd_en;
  assign bus.fm_rd_addr = ADDR_W'(w_rd_row) * ADDR_W'(WIDTH) + ADDR_W'(w_rd_col);

  // ---------------------------------------------------------------- pixel path
  // RAM data lands one cycle after the read; the delayed enable marks a live pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_en_d1 <= 1'b0;
    end else begin
      r_rd_en_d1 <= w_rd_en;
    end
  end

  assign w_pix_vld     = r_rd_en_d1;
  assign bus.buf_pixel = w_pix_vld ? bus.fm_rd_data : '0;

  conv2_pos_cnt #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_px_pos (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_start_acc),
    .i_en      (w_pix_vld),
    .o_row     (w_px_row),
    .o_col     (w_px_col),
    .o_col_end (w_px_col_end),
    .o_last    (w_px_last)
  );

  // ---------------------------------------------------------------- window qualification
  // A pixel completes an interior window only once two full rows and two columns of the
  // current row are behind it; windows straddling the row wrap fall out of this test.
  assign w_qual = w_pix_vld && (w_px_col >= COL_W'(KM1)) && (w_px_row >= ROW_W'(KM1));

  always_comb begin
    w_tag_in = '0;
    if (w_qual) begin
      w_tag_in.vld  = 1'b1;
      w_tag_in.last = w_px_last;
      w_tag_in.row  = WIN_COORD_W'(w_px_row - ROW_W'(KM1));
      w_tag_in.col  = WIN_COORD_W'(w_px_col - COL_W'(KM1));
    end
  end

  // Tag rides alongside the window buffer so it lines up with the window it describes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_LAT; i++) begin
        r_tag_pipe[i] <= '0;
      end
    end else begin
      r_tag_pipe[0] <= w_tag_in;
      for (int i = 1; i < BUF_LAT; i++) begin
        r_tag_pipe[i] <= r_tag_pipe[i-1];
      end
    end
  end

  assign w_tag_out     = r_tag_pipe[BUF_LAT-1];
  assign bus.win_valid = w_tag_out.vld;
  assign bus.win_last  = w_tag_out.last;
  assign bus.win_row   = w_tag_out.row;
  assign bus.win_col   = w_tag_out.col;

  assign bus.busy = w_busy;
  assign bus.done = w_done;

`ifdef CONV2_SEQ_PERF_EN
  // ---------------------------------------------------------------- perf counters
  logic [15:0] r_perf_frames;
  logic [31:0] r_perf_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_frames <= '0;
      r_perf_busy   <= '0;
    end else begin
      if (w_done) begin
        r_perf_frames <= r_perf_frames + 16'd1;
      end
      if (w_busy && (r_perf_busy != '1)) begin
        r_perf_busy <= r_perf_busy + 32'd1;
      end
    end
  end

  assign perf_frames   = r_perf_frames;
  assign perf_busy_cyc = r_perf_busy;
`endif

endmodule

// File: tb/tb_conv2_seq_ctrl.sv
module tb_conv2_seq_ctrl;
  import mnist_pkg::*;

  localparam int W    = 13;
  localparam int H    = 13;
  localparam int WH   = W * H;
  localparam int BL   = 1;
  localparam int AW   = 8;
  localparam int LAT  = WH + BL + 2;
  localparam int NK   = LAT + 4;
  localparam int NWIN = (W - 2) * (H - 2);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic [7:0] mem [0:255];

  logic       cap_en   [0:NK];
  logic [7:0] cap_addr [0:NK];
  logic [7:0] cap_pix  [0:NK];
  logic       cap_wv   [0:NK];
  logic [3:0] cap_wr   [0:NK];
  logic [3:0] cap_wc   [0:NK];
  logic       cap_wl   [0:NK];
  logic       cap_busy [0:NK];
  logic       cap_done [0:NK];

  conv2_seq_ctrl_if #(.ADDR_W(AW)) bus_if ();

`ifdef CONV2_SEQ_PERF_EN
  logic [15:0] perf_frames;
  logic [31:0] perf_busy_cyc;
`endif

  conv2_seq_ctrl #(
    .WIDTH   (W),
    .HEIGHT  (H),
    .ADDR_W  (AW),
    .BUF_LAT (BL)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus_if)
`ifdef CONV2_SEQ_PERF_EN
    ,
    .perf_frames   (perf_frames),
    .perf_busy_cyc (perf_busy_cyc)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous RAM: data valid the cycle after the read.
  always @(posedge clk) begin
    if (bus_if.fm_rd_en) bus_if.fm_rd_data <= mem[bus_if.fm_rd_addr];
  end

  // Reference model. k = cycles since the cycle in which start was accepted.
  function automatic logic m_en(input int k);
    return (k >= 1) && (k <= WH);
  endfunction

  function automatic logic [7:0] m_pix(input int k);
    if (k >= 2 && k <= WH + 1) return mem[k-2];
    return 8'h00;
  endfunction

  function automatic logic m_wv(input int k);
    int p;
    p = k - 2 - BL;
    return (p >= 0) && (p < WH) && ((p % W) >= 2) && ((p / W) >= 2);
  endfunction

  function automatic logic [3:0] m_wr(input int k);
    if (m_wv(k)) return 4'((k - 2 - BL) / W - 2);
    return 4'd0;
  endfunction

  function automatic logic [3:0] m_wc(input int k);
    if (m_wv(k)) return 4'((k - 2 - BL) % W - 2);
    return 4'd0;
  endfunction

  function automatic logic m_wl(input int k);
    return m_wv(k) && ((k - 2 - BL) == WH - 1);
  endfunction

  function automatic logic m_busy(input int k);
    return (k >= 1) && (k <= WH + BL + 1);
  endfunction

  function automatic logic m_done(input int k);
    return k == LAT;
  endfunction

  // Golden 3x3 window (all 8 channels) straight from the RAM image.
  function automatic logic [71:0] m_window(input int k);
    logic [71:0] v;
    v = '0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        v[(dr*3+dc)*8 +: 8] = mem[(int'(m_wr(k)) + dr) * W + int'(m_wc(k)) + dc];
    return v;
  endfunction

  // Window as a buffer fed by the observed buf_pixel stream would hold it.
  function automatic logic [71:0] obs_window(input int k);
    logic [71:0] v;
    v = '0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        v[(dr*3+dc)*8 +: 8] = cap_pix[k - BL - (2-dr)*W - (2-dc)];
    return v;
  endfunction

  task automatic fill_ramp();
    for (int i = 0; i < 256; i++) mem[i] = i[7:0];
  endtask

  task automatic fill_random();
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
  endtask

  task automatic start_frame();
    @(negedge clk);
    bus_if.start = 1'b1;
  endtask

  // Records nk cycles after an accepted start; optionally pulses start in cycles inj_a/inj_b.
  task automatic capture(input int nk, input int inj_a, input int inj_b);
    for (int k = 1; k <= nk; k++) begin
      @(negedge clk);
      bus_if.start = 1'b0;
      cap_en[k]   = bus_if.fm_rd_en;
      cap_addr[k] = bus_if.fm_rd_addr;
      cap_pix[k]  = bus_if.buf_pixel;
      cap_wv[k]   = bus_if.win_valid;
      cap_wr[k]   = bus_if.win_row;
      cap_wc[k]   = bus_if.win_col;
      cap_wl[k]   = bus_if.win_last;
      cap_busy[k] = bus_if.busy;
      cap_done[k] = bus_if.done;
      if (k == inj_a || k == inj_b) bus_if.start = 1'b1;
    end
  endtask

  task automatic test_reset();
    bus_if.start = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus_if.busy, bus_if.done} !== 2'b00) begin
      failures++; $display("FAIL reset_handshake got=%b exp=00", {bus_if.busy, bus_if.done});
    end
    checks++;
    if ({bus_if.fm_rd_en, bus_if.fm_rd_addr, bus_if.buf_pixel} !== 17'd0) begin
      failures++; $display("FAIL reset_read got=%h exp=0", {bus_if.fm_rd_en, bus_if.fm_rd_addr, bus_if.buf_pixel});
    end
    checks++;
    if ({bus_if.win_valid, bus_if.win_row, bus_if.win_col, bus_if.win_last} !== 10'd0) begin
      failures++; $display("FAIL reset_window got=%h exp=0", {bus_if.win_valid, bus_if.win_row, bus_if.win_col, bus_if.win_last});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus_if.busy, bus_if.done, bus_if.fm_rd_en, bus_if.win_valid} !== 4'b0000) begin
      failures++; $display("FAIL idle_after_reset got=%b exp=0000", {bus_if.busy, bus_if.done, bus_if.fm_rd_en, bus_if.win_valid});
    end
`ifdef CONV2_SEQ_PERF_EN
    checks++;
    if ({perf_frames, perf_busy_cyc} !== 48'd0) begin
      failures++; $display("FAIL reset_perf got=%h exp=0", {perf_frames, perf_busy_cyc});
    end
`endif
  endtask

  task automatic test_basic_frame();
    int nwin, done_k;
    logic [3:0] fr, fc, lr, lc;
    logic first_seen;
    nwin = 0; done_k = -1; first_seen = 1'b0;
    fr = 4'hF; fc = 4'hF; lr = 4'hF; lc = 4'hF;
    fill_ramp();
    start_frame();
    capture(NK, -1, -1);
    for (int k = 1; k <= NK; k++) begin
      checks++;
      if (cap_en[k] !== m_en(k)) begin
        failures++; $display("FAIL basic_rd_en k=%0d got=%b exp=%b", k, cap_en[k], m_en(k));
      end
      if (m_en(k)) begin
        checks++;
        if (cap_addr[k] !== 8'(k - 1)) begin
          failures++; $display("FAIL basic_rd_addr k=%0d got=%0d exp=%0d", k, cap_addr[k], k - 1);
        end
      end
      checks++;
      if (cap_busy[k] !== m_busy(k)) begin
        failures++; $display("FAIL basic_busy k=%0d got=%b exp=%b", k, cap_busy[k], m_busy(k));
      end
      checks++;
      if (cap_pix[k] !== m_pix(k)) begin
        failures++; $display("FAIL basic_pixel k=%0d got=%h exp=%h", k, cap_pix[k], m_pix(k));
      end
      if (cap_wv[k] === 1'b1) begin
        nwin++;
        if (!first_seen) begin fr = cap_wr[k]; fc = cap_wc[k]; first_seen = 1'b1; end
      end
      if (cap_wl[k] === 1'b1) begin lr = cap_wr[k]; lc = cap_wc[k]; end
      if (cap_done[k] === 1'b1 && done_k < 0) done_k = k;
    end
    checks++;
    if (nwin !== NWIN) begin failures++; $display("FAIL basic_win_count got=%0d exp=%0d", nwin, NWIN); end
    checks++;
    if ({fr, fc} !== 8'h00) begin failures++; $display("FAIL basic_first_win got=(%0d,%0d) exp=(0,0)", fr, fc); end
    checks++;
    if ({lr, lc} !== {4'(H - 3), 4'(W - 3)}) begin
      failures++; $display("FAIL basic_last_win got=(%0d,%0d) exp=(%0d,%0d)", lr, lc, H - 3, W - 3);
    end
    checks++;
    if (done_k !== LAT) begin failures++; $display("FAIL basic_done_latency got=%0d exp=%0d", done_k, LAT); end
  endtask

  task automatic test_row_wrap();
    fill_random();
    start_frame();
    capture(NK, -1, -1);
    for (int k = 1; k <= NK; k++) begin
      checks++;
      if (cap_wv[k] !== m_wv(k)) begin
        failures++; $display("FAIL wrap_valid k=%0d pcol=%0d got=%b exp=%b", k, (k - 2 - BL) % W, cap_wv[k], m_wv(k));
      end
      checks++;
      if ({cap_wr[k], cap_wc[k], cap_wl[k]} !== {m_wr(k), m_wc(k), m_wl(k)}) begin
        failures++; $display("FAIL wrap_coord k=%0d got=(%0d,%0d,%b) exp=(%0d,%0d,%b)",
                             k, cap_wr[k], cap_wc[k], cap_wl[k], m_wr(k), m_wc(k), m_wl(k));
      end
      if (cap_wv[k] === 1'b1) begin
        checks++;
        if (cap_wc[k] > 4'(W - 3)) begin
          failures++; $display("FAIL wrap_col_range k=%0d got=%0d exp<=%0d", k, cap_wc[k], W - 3);
        end
      end
      if (m_wv(k)) begin
        checks++;
        if (obs_window(k) !== m_window(k)) begin
          failures++; $display("FAIL wrap_window_data k=%0d got=%h exp=%h", k, obs_window(k), m_window(k));
        end
      end
    end
  endtask

  task automatic test_start_while_busy();
    int ndone, nwin;
    ndone = 0; nwin = 0;
    fill_random();
    start_frame();
    capture(NK, 50, LAT);
    for (int k = 1; k <= NK; k++) begin
      checks++;
      if ({cap_busy[k], cap_done[k]} !== {m_busy(k), m_done(k)}) begin
        failures++; $display("FAIL busy_start_handshake k=%0d got=%b%b exp=%b%b",
                             k, cap_busy[k], cap_done[k], m_busy(k), m_done(k));
      end
      checks++;
      if ({cap_en[k], cap_wv[k]} !== {m_en(k), m_wv(k)}) begin
        failures++; $display("FAIL busy_start_stream k=%0d got=%b%b exp=%b%b", k, cap_en[k], cap_wv[k], m_en(k), m_wv(k));
      end
      if (cap_done[k] === 1'b1) ndone++;
      if (cap_wv[k] === 1'b1) nwin++;
    end
    checks++;
    if (ndone !== 1) begin failures++; $display("FAIL busy_start_done_count got=%0d exp=1", ndone); end
    checks++;
    if (nwin !== NWIN) begin failures++; $display("FAIL busy_start_win_count got=%0d exp=%0d", nwin, NWIN); end
  endtask

  task automatic test_back_to_back();
    fill_random();
    start_frame();
    capture(LAT + 1, LAT + 1, -1);
    checks++;
    if ({cap_done[LAT], cap_busy[LAT + 1]} !== 2'b10) begin
      failures++; $display("FAIL b2b_first_done got=%b%b exp=10", cap_done[LAT], cap_busy[LAT + 1]);
    end
    capture(NK, -1, -1);
    for (int k = 1; k <= NK; k++) begin
      checks++;
      if ({cap_en[k], cap_busy[k], cap_done[k]} !== {m_en(k), m_busy(k), m_done(k)}) begin
        failures++; $display("FAIL b2b_ctrl k=%0d got=%b%b%b exp=%b%b%b",
                             k, cap_en[k], cap_busy[k], cap_done[k], m_en(k), m_busy(k), m_done(k));
      end
      if (m_en(k)) begin
        checks++;
        if (cap_addr[k] !== 8'(k - 1)) begin
          failures++; $display("FAIL b2b_rd_addr k=%0d got=%0d exp=%0d", k, cap_addr[k], k - 1);
        end
      end
      checks++;
      if ({cap_wv[k], cap_wr[k], cap_wc[k], cap_wl[k]} !== {m_wv(k), m_wr(k), m_wc(k), m_wl(k)}) begin
        failures++; $display("FAIL b2b_window k=%0d got=%b(%0d,%0d)%b exp=%b(%0d,%0d)%b",
                             k, cap_wv[k], cap_wr[k], cap_wc[k], cap_wl[k], m_wv(k), m_wr(k), m_wc(k), m_wl(k));
      end
      if (m_wv(k)) begin
        checks++;
        if (obs_window(k) !== m_window(k)) begin
          failures++; $display("FAIL b2b_window_data k=%0d got=%h exp=%h", k, obs_window(k), m_window(k));
        end
      end
    end
  endtask

`ifdef CONV2_SEQ_PERF_EN
  task automatic test_perf();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int f = 0; f < 3; f++) begin
      fill_random();
      start_frame();
      capture(LAT + 1, -1, -1);
    end
    checks++;
    if (perf_frames !== 16'd3) begin failures++; $display("FAIL perf_frames got=%0d exp=3", perf_frames); end
    checks++;
    if (perf_busy_cyc !== 32'(3 * (WH + BL + 1))) begin
      failures++; $display("FAIL perf_busy_cyc got=%0d exp=%0d", perf_busy_cyc, 3 * (WH + BL + 1));
    end
  endtask
`endif

  task automatic test_reset_mid_frame();
    int nwin;
    nwin = 0;
    fill_random();
    start_frame();
    capture(80, -1, -1);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus_if.busy, bus_if.done, bus_if.fm_rd_en, bus_if.fm_rd_addr, bus_if.buf_pixel,
         bus_if.win_valid, bus_if.win_row, bus_if.win_col, bus_if.win_last} !== 30'd0) begin
      failures++; $display("FAIL midrst_outputs got=%h exp=0",
                           {bus_if.busy, bus_if.done, bus_if.fm_rd_en, bus_if.fm_rd_addr, bus_if.buf_pixel,
                            bus_if.win_valid, bus_if.win_row, bus_if.win_col, bus_if.win_last});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fill_random();
    start_frame();
    capture(NK, -1, -1);
    for (int k = 1; k <= NK; k++) begin
      checks++;
      if ({cap_wv[k], cap_wr[k], cap_wc[k]} !== {m_wv(k), m_wr(k), m_wc(k)}) begin
        failures++; $display("FAIL midrst_window k=%0d got=%b(%0d,%0d) exp=%b(%0d,%0d)",
                             k, cap_wv[k], cap_wr[k], cap_wc[k], m_wv(k), m_wr(k), m_wc(k));
      end
      if (m_wv(k)) begin
        checks++;
        if (obs_window(k) !== m_window(k)) begin
          failures++; $display("FAIL midrst_window_data k=%0d got=%h exp=%h", k, obs_window(k), m_window(k));
        end
      end
      if (cap_wv[k] === 1'b1) nwin++;
    end
    checks++;
    if (nwin !== NWIN) begin failures++; $display("FAIL midrst_win_count got=%0d exp=%0d", nwin, NWIN); end
  endtask

  initial begin
    bus_if.start = 1'b0;
    test_reset();
    test_basic_frame();
    test_row_wrap();
    test_start_while_busy();
    test_back_to_back();
`ifdef CONV2_SEQ_PERF_EN
    test_perf();
`endif
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
